// File: rtl/mist_video_timing_pkg.sv
// Shared constants and helpers for the MiST video timing generator:
// pattern selector encoding, colour-bar table and pixel-clock divisor mapping.
package mist_video_timing_pkg;

    typedef enum logic [1:0] {
        PAT_PASS    = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_BORDER  = 2'd3
    } pattern_e;

    // {R,G,B} per bar, index 0 at the left: white, yellow, cyan, green,
    // magenta, red, blue, black
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic logic [4:0] pix_divisor(input logic [3:0] sel);
        return (sel == 4'd0) ? 5'd4 : ({1'b0, sel} + 5'd1);
    endfunction

endpackage

// File: rtl/mist_video_timing_gen_test_pattern.sv
// Combinational test-pattern source: colour bars, checkerboard, border or
// pass-through of the core pixel, selected by pattern code.
module video_test_pattern
    import mist_video_timing_pkg::*;
#(
    parameter int H_ACTIVE    = 256,
    parameter int V_ACTIVE    = 224,
    parameter int HCNT_WIDTH  = 9,
    parameter int VCNT_WIDTH  = 9,
    parameter int COLOR_DEPTH = 6
) (
    input  logic [HCNT_WIDTH-1:0]  h,
    input  logic [VCNT_WIDTH-1:0]  v,
    input  pattern_e               sel,
    input  logic [COLOR_DEPTH-1:0] r_in,
    input  logic [COLOR_DEPTH-1:0] g_in,
    input  logic [COLOR_DEPTH-1:0] b_in,
    output logic [COLOR_DEPTH-1:0] r_out,
    output logic [COLOR_DEPTH-1:0] g_out,
    output logic [COLOR_DEPTH-1:0] b_out
);

    localparam int BAR_W = HCNT_WIDTH + 3;
    localparam logic [HCNT_WIDTH-1:0] H_LAST_ACT = HCNT_WIDTH'(H_ACTIVE - 1);
    localparam logic [VCNT_WIDTH-1:0] V_LAST_ACT = VCNT_WIDTH'(V_ACTIVE - 1);

    logic [2:0]       bar_idx;
    logic [2:0]       bar_rgb;
    logic [BAR_W-1:0] h_x8;
    logic             checker_on;
    logic             border_on;

    always_comb begin
        // bar index = floor(h*8/H_ACTIVE) via threshold comparisons
        h_x8    = {h, 3'b000};
        bar_idx = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (h_x8 >= BAR_W'(k * H_ACTIVE)) begin
                bar_idx = 3'(k);
            end
        end
        bar_rgb    = BAR_RGB[bar_idx];
        checker_on = h[3] ^ v[3];
        border_on  = (h == '0) || (h == H_LAST_ACT) || (v == '0) || (v == V_LAST_ACT);

        r_out = r_in;
        g_out = g_in;
        b_out = b_in;
        case (sel)
            PAT_BARS: begin
                r_out = {COLOR_DEPTH{bar_rgb[2]}};
                g_out = {COLOR_DEPTH{bar_rgb[1]}};
                b_out = {COLOR_DEPTH{bar_rgb[0]}};
            end
            PAT_CHECKER: begin
                r_out = {COLOR_DEPTH{checker_on}};
                g_out = {COLOR_DEPTH{checker_on}};
                b_out = {COLOR_DEPTH{checker_on}};
            end
            PAT_BORDER: begin
                r_out = {COLOR_DEPTH{border_on}};
                g_out = {COLOR_DEPTH{border_on}};
                b_out = {COLOR_DEPTH{border_on}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mist_video_timing_gen.sv
// Pixel clock enable, raster counters, blank/sync and RGB stream for MiST cores.
// Build option VIDEO_TIMING_PATTERN_EN compiles in the test-pattern generator.
module mist_video_timing_gen
    import mist_video_timing_pkg::*;
#(
    parameter int H_ACTIVE    = 256,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 32,
    parameter int H_BP        = 80,
    parameter int V_ACTIVE    = 224,
    parameter int V_FP        = 8,
    parameter int V_SYNC      = 3,
    parameter int V_BP        = 29,
    parameter int HCNT_WIDTH  = 9,
    parameter int VCNT_WIDTH  = 9,
    parameter int COLOR_DEPTH = 6
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [3:0]             ce_divider,
    input  logic [1:0]             pattern_sel,
    input  logic [COLOR_DEPTH-1:0] r_in,
    input  logic [COLOR_DEPTH-1:0] g_in,
    input  logic [COLOR_DEPTH-1:0] b_in,
    output logic                   ce_pix,
    output logic [HCNT_WIDTH-1:0]  hcount,
    output logic [VCNT_WIDTH-1:0]  vcount,
    output logic                   frame,
    output logic [COLOR_DEPTH-1:0] R,
    output logic [COLOR_DEPTH-1:0] G,
    output logic [COLOR_DEPTH-1:0] B,
    output logic                   HBlank,
    output logic                   VBlank,
    output logic                   HSync,
    output logic                   VSync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HCNT_WIDTH-1:0] H_LAST   = HCNT_WIDTH'(H_TOTAL - 1);
    localparam logic [HCNT_WIDTH-1:0] H_ACT    = HCNT_WIDTH'(H_ACTIVE);
    localparam logic [HCNT_WIDTH-1:0] HS_FIRST = HCNT_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [HCNT_WIDTH-1:0] HS_LAST  = HCNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VCNT_WIDTH-1:0] V_LAST   = VCNT_WIDTH'(V_TOTAL - 1);
    localparam logic [VCNT_WIDTH-1:0] V_ACT    = VCNT_WIDTH'(V_ACTIVE);
    localparam logic [VCNT_WIDTH-1:0] VS_FIRST = VCNT_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [VCNT_WIDTH-1:0] VS_LAST  = VCNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [3:0]             div_q, div_d, div_reload;
    logic                   ce_q, ce_d;
    logic [HCNT_WIDTH-1:0]  hcount_q, hcount_d;
    logic [VCNT_WIDTH-1:0]  vcount_q, vcount_d;
    logic                   hblank_q, hblank_d, vblank_q, vblank_d;
    logic                   hsync_q, hsync_d, vsync_q, vsync_d;
    logic [COLOR_DEPTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [COLOR_DEPTH-1:0] pix_r, pix_g, pix_b;

    assign div_reload = 4'(pix_divisor(ce_divider) - 5'd1);

`ifdef VIDEO_TIMING_PATTERN_EN
    video_test_pattern #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .HCNT_WIDTH (HCNT_WIDTH),
        .VCNT_WIDTH (VCNT_WIDTH),
        .COLOR_DEPTH(COLOR_DEPTH)
    ) u_pattern (
        .h    (hcount_q),
        .v    (vcount_q),
        .sel  (pattern_e'(pattern_sel)),
        .r_in (r_in),
        .g_in (g_in),
        .b_in (b_in),
        .r_out(pix_r),
        .g_out(pix_g),
        .b_out(pix_b)
    );
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = ^pattern_sel;
    assign pix_r = r_in;
    assign pix_g = g_in;
    assign pix_b = b_in;
`endif

    always_comb begin
        div_d    = div_q - 4'd1;
        ce_d     = 1'b0;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        hblank_d = hblank_q;
        vblank_d = vblank_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        r_d      = r_q;
        g_d      = g_q;
        b_d      = b_q;

        if (div_q == '0) begin
            div_d = div_reload;
            ce_d  = 1'b1;
        end

        // counters advance and video decodes the pre-increment position
        if (ce_q) begin
            hcount_d = (hcount_q == H_LAST) ? '0 : hcount_q + HCNT_WIDTH'(1);
            if (hcount_q == H_LAST) begin
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + VCNT_WIDTH'(1);
            end
            hblank_d = (hcount_q >= H_ACT);
            vblank_d = (vcount_q >= V_ACT);
            hsync_d  = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
            vsync_d  = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
            r_d      = (hblank_d || vblank_d) ? '0 : pix_r;
            g_d      = (hblank_d || vblank_d) ? '0 : pix_g;
            b_d      = (hblank_d || vblank_d) ? '0 : pix_b;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_q    <= div_reload;
            ce_q     <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
        end else begin
            div_q    <= div_d;
            ce_q     <= ce_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
        end
    end

    assign ce_pix = ce_q;
    assign frame  = ce_q && (hcount_q == '0) && (vcount_q == '0);
    assign hcount = hcount_q;
    assign vcount = vcount_q;
    assign HBlank = hblank_q;
    assign VBlank = vblank_q;
    assign HSync  = hsync_q;
    assign VSync  = vsync_q;
    assign R      = r_q;
    assign G      = g_q;
    assign B      = b_q;

endmodule

// File: tb/tb_mist_video_timing_gen.sv
// Randomized bench for mist_video_timing_gen: small raster checked every clock
// against a pixel-index reference model, plus a full-size instance for bar colours.
module tb_mist_video_timing_gen;

    localparam int S_HA = 8, S_HFP = 2, S_HS = 2, S_HBP = 2;
    localparam int S_VA = 4, S_VFP = 1, S_VS = 1, S_VBP = 1;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
`ifdef VIDEO_TIMING_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, rst_full;
    logic [3:0] ce_divider;
    logic [1:0] pattern_sel;
    logic [5:0] r_in, g_in, b_in;

    logic       ce_pix, frame, hblank, vblank, hsync, vsync;
    logic [3:0] hcount, vcount;
    logic [5:0] r_o, g_o, b_o;

    logic       f_ce, f_frame, f_hb, f_vb, f_hs, f_vs;
    logic [8:0] f_h, f_v;
    logic [5:0] f_r, f_g, f_b;

    always #5 clk = ~clk;

    mist_video_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .HCNT_WIDTH(4), .VCNT_WIDTH(4), .COLOR_DEPTH(6)
    ) dut (
        .clk_sys(clk), .reset(reset), .ce_divider(ce_divider), .pattern_sel(pattern_sel),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount), .frame(frame),
        .R(r_o), .G(g_o), .B(b_o),
        .HBlank(hblank), .VBlank(vblank), .HSync(hsync), .VSync(vsync)
    );

    mist_video_timing_gen dut_full (
        .clk_sys(clk), .reset(rst_full), .ce_divider(4'd1), .pattern_sel(2'd1),
        .r_in(6'h15), .g_in(6'h15), .b_in(6'h15),
        .ce_pix(f_ce), .hcount(f_h), .vcount(f_v), .frame(f_frame),
        .R(f_r), .G(f_g), .B(f_b),
        .HBlank(f_hb), .VBlank(f_vb), .HSync(f_hs), .VSync(f_vs)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    int   cyc, next_pulse, adv, pulses, last_frame_pulse, first_div;
    bit   prev_ce, exp_ce, first_ce_seen;
    logic e_hb, e_vb, e_hs, e_vs;
    logic [5:0] e_r, e_g, e_b;
    int   fcyc, f_next, f_adv;
    bit   f_prev_ce, f_exp;

    function automatic int div_of(input logic [3:0] d);
        return (d == 4'd0) ? 4 : int'(d) + 1;
    endfunction

    function automatic logic [2:0] bar_colour(input int i);
        case (i)
            0: return 3'b111;   // white
            1: return 3'b110;   // yellow
            2: return 3'b011;   // cyan
            3: return 3'b010;   // green
            4: return 3'b101;   // magenta
            5: return 3'b100;   // red
            6: return 3'b001;   // blue
            default: return 3'b000;
        endcase
    endfunction

    task automatic model_reset();
        cyc = 0; adv = 0; pulses = 0; prev_ce = 0; first_ce_seen = 0;
        first_div = div_of(ce_divider);
        next_pulse = first_div;
        last_frame_pulse = -1;
        e_hb = 0; e_vb = 0; e_hs = 1; e_vs = 1; e_r = 0; e_g = 0; e_b = 0;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_ce", ce_pix, 0);   check_eq("rst_frame", frame, 0);
        check_eq("rst_h", hcount, 0);    check_eq("rst_v", vcount, 0);
        check_eq("rst_hb", hblank, 0);   check_eq("rst_vb", vblank, 0);
        check_eq("rst_hs", hsync, 1);    check_eq("rst_vs", vsync, 1);
        check_eq("rst_r", r_o, 0);       check_eq("rst_g", g_o, 0);
        check_eq("rst_b", b_o, 0);
    endtask

    // expected stage-2 outputs for linear pixel index p with the inputs now present
    task automatic calc_video(input int p);
        int h, v;
        bit on;
        logic [2:0] c;
        h = p % S_HT;
        v = (p / S_HT) % S_VT;
        e_hb = (h >= S_HA);
        e_vb = (v >= S_VA);
        e_hs = !(h >= S_HA + S_HFP && h < S_HA + S_HFP + S_HS);
        e_vs = !(v >= S_VA + S_VFP && v < S_VA + S_VFP + S_VS);
        e_r = r_in; e_g = g_in; e_b = b_in;
        if (PAT_EN && pattern_sel != 2'd0) begin
            if (pattern_sel == 2'd1) begin
                c = bar_colour((h * 8) / S_HA);
            end else begin
                if (pattern_sel == 2'd2) on = (((h / 8) + (v / 8)) % 2) == 1;
                else on = (h == 0) || (h == S_HA - 1) || (v == 0) || (v == S_VA - 1);
                c = {3{on}};
            end
            e_r = {6{c[2]}}; e_g = {6{c[1]}}; e_b = {6{c[0]}};
        end
        if (e_hb || e_vb) begin
            e_r = 0; e_g = 0; e_b = 0;
        end
    endtask

    task automatic check_full_pixel(input int p);
        logic [5:0] er, eg, eb;
        if (PAT_EN) begin
            er = (p < 192) ? 6'd63 : 6'd0;          // white / yellow / black
            eg = (p < 192) ? 6'd63 : 6'd0;
            eb = (p == 0) ? 6'd63 : 6'd0;
        end else begin
            er = 6'h15; eg = 6'h15; eb = 6'h15;
        end
        check_eq("full_r", f_r, er); check_eq("full_g", f_g, eg); check_eq("full_b", f_b, eb);
        check_eq("full_h", f_h, p + 1); check_eq("full_v", f_v, 0);
        check_eq("full_hb", f_hb, 0); check_eq("full_vb", f_vb, 0);
        check_eq("full_hs", f_hs, 1); check_eq("full_vs", f_vs, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        fcyc++;
        if (prev_ce) begin
            calc_video(adv);
            adv++;
        end
        exp_ce = (cyc == next_pulse);
        if (exp_ce) begin
            next_pulse = cyc + div_of(ce_divider);
            pulses++;
        end
        check_eq("ce_pix", ce_pix, exp_ce);
        check_eq("hcount", hcount, adv % S_HT);
        check_eq("vcount", vcount, (adv / S_HT) % S_VT);
        check_eq("frame", frame, exp_ce && (adv % (S_HT * S_VT) == 0));
        check_eq("HBlank", hblank, e_hb);
        check_eq("VBlank", vblank, e_vb);
        check_eq("HSync", hsync, e_hs);
        check_eq("VSync", vsync, e_vs);
        check_eq("R", r_o, e_r);
        check_eq("G", g_o, e_g);
        check_eq("B", b_o, e_b);
        if (ce_pix && !first_ce_seen) begin
            first_ce_seen = 1;
            check_eq("first_ce_cycle", cyc, first_div);
        end
        if (frame) begin
            if (last_frame_pulse >= 0) check_eq("frame_period", pulses - last_frame_pulse, S_HT * S_VT);
            last_frame_pulse = pulses;
        end
        prev_ce = exp_ce;

        if (fcyc < 600) begin
            if (f_prev_ce) begin
                if (f_adv == 0 || f_adv == 32 || f_adv == 224) check_full_pixel(f_adv);
                f_adv++;
            end
            f_exp = (fcyc == f_next);
            if (f_exp) f_next = fcyc + 2;
            check_eq("full_ce", f_ce, f_exp);
            check_eq("full_frame", f_frame, f_exp && f_adv == 0);
            f_prev_ce = f_exp;
        end
    endtask

    task automatic drive(input bit rand_sel, input bit rand_div, input bit r_from_h);
        r_in = r_from_h ? {2'b00, hcount} : 6'($urandom);
        g_in = 6'($urandom);
        b_in = 6'($urandom);
        if (rand_sel) pattern_sel = 2'($urandom);
        if (rand_div && $urandom_range(0, 29) == 0) ce_divider = 4'($urandom);
    endtask

    initial begin
        reset = 1; rst_full = 1;
        ce_divider = 4'd0; pattern_sel = 2'd0;
        r_in = 0; g_in = 0; b_in = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 0; rst_full = 0;
        model_reset();
        fcyc = 0; f_next = 2; f_adv = 0; f_prev_ce = 0;

        // divide-by-4 default, pass-through with random pixel data
        repeat (800) begin step(); drive(0, 0, 0); end

        // random patterns and occasional divisor changes
        repeat (1200) begin step(); drive(1, 1, 0); end

        // divisor 2, then 3 switched in mid-period
        pattern_sel = 2'd0;
        ce_divider = 4'd1;
        repeat (41) begin step(); drive(0, 0, 0); end
        ce_divider = 4'd2;
        repeat (60) begin step(); drive(0, 0, 0); end

        // asynchronous reset between clock edges
        @(posedge clk);
        #3;
        reset = 1;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        model_reset();

        // restart from 0,0 with pixel index fed back as red data
        repeat (500) begin step(); drive(0, 0, 1); end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mist_video_timing_gen.md
# mist_video_timing_gen

Source-side video timing and test-pattern generator for MiST cores. It produces the pixel clock enable, counters, blanking, sync and RGB stream that the dual video pipeline (scandoubler, OSD, cofi, HDMI path) consumes on its core-video input. Cores use it in two ways: as the raster master, fetching pixels via the leading counters, or as a bring-up pattern source.

## Interface

Parameters:
- H_ACTIVE, 256, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 32, HSync width in pixels
- H_BP, 80, horizontal back porch in pixels
- V_ACTIVE, 224, visible lines per frame
- V_FP, 8, vertical front porch in lines
- V_SYNC, 3, VSync width in lines
- V_BP, 29, vertical back porch in lines
- HCNT_WIDTH, 9, hcount width; must hold H_TOTAL-1
- VCNT_WIDTH, 9, vcount width; must hold V_TOTAL-1
- COLOR_DEPTH, 6, bits per colour channel (1-8)

Ports:
- clk_sys  in  1  master clock
- reset  in  1  asynchronous, active-high
- ce_divider  in  4  pixel clock divisor: 0 → /4, n≥1 → /(n+1)
- pattern_sel  in  2  0 pass-through, 1 colour bars, 2 checkerboard, 3 border
- r_in, g_in, b_in  in  COLOR_DEPTH  core pixel for the position on hcount/vcount
- ce_pix  out  1  one-clk_sys pulse per pixel
- hcount  out  HCNT_WIDTH  fetch position, leads the video outputs by one pixel
- vcount  out  VCNT_WIDTH  fetch line, leads the video outputs by one pixel
- frame  out  1  pulse coincident with ce_pix when hcount=0 and vcount=0
- R, G, B  out  COLOR_DEPTH  pixel data
- HBlank, VBlank  out  1  active-high blanking
- HSync, VSync  out  1  active-low sync

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way.
- Divider: D = 4 if ce_divider=0, else ce_divider+1. A down-counter reloads D-1 and asserts registered ce_pix when it reaches 0. ce_divider is sampled only at reload, so a change takes effect after the current period.
- Stage 1 (counters): on each clock with ce_pix=1, hcount increments, wrapping at H_TOTAL-1 to 0. On hcount wrap, vcount increments, wrapping at V_TOTAL-1 to 0.
- Stage 2 (video): on the same edge, outputs take the decode of the old counter values:
  - HBlank = h ≥ H_ACTIVE
  - VBlank = v ≥ V_ACTIVE
  - HSync = 0 for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - VSync = 0 for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
  - RGB comes from the pattern or from r/g/b_in.
- VSync/VBlank therefore change only at h=0, aligned to the line start.
- R/G/B are forced to 0 whenever HBlank or VBlank is active, in every mode.
- Colour bars: bar index i = (h·8)/H_ACTIVE, computed as a comparison chain, no divider. G = ~i[2], R = ~i[1], B = ~i[0]. Each channel is all-ones or 0. Order: white, yellow, cyan, green, magenta, red, blue, black.
- Checkerboard: all channels all-ones when h[3]^v[3], else 0.
- Border: white when h∈{0,H_ACTIVE-1} or v∈{0,V_ACTIVE-1}, else 0.

## Timing

- Reset values: divider=D-1 (for the current ce_divider), ce_pix=0, frame=0, hcount=0, vcount=0, R=G=B=0, HBlank=0, VBlank=0, HSync=1, VSync=1.
- The first ce_pix pulse occurs D cycles after reset deasserts.
- Reset asserted mid-frame forces all outputs to their reset values immediately, without waiting for a clock.
- Pass-through latency: r_in presented while hcount=h appears on R together with the blank/sync flags for h, one ce_pix later. All stage-2 outputs change on the same clk_sys edge and hold between pulses.
- Downstream blocks sample qualified by ce_pix, which is why outputs update at the edge closing each ce_pix cycle.

## Configuration

- VIDEO_TIMING_PATTERN_EN defined: the pattern generator is compiled in and pattern_sel is honoured.
- VIDEO_TIMING_PATTERN_EN undefined: pattern_sel is ignored and the block is pass-through only. Timing, blanking and latency are identical in both builds.

## Structure

- Package mist_video_timing_pkg holds:
  - the pattern_sel encoding constants
  - the bar colour table
  - a divisor function mapping ce_divider to D
- Sub-module video_test_pattern: combinational, takes counters and selector, returns RGB. Instantiated only under VIDEO_TIMING_PATTERN_EN.

## Test plan

- Release reset with ce_divider=0 → first ce_pix at clock 4, then every 4 clocks. HSync=1 and RGB=0 before that pulse.
- Run with H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1:
  - HSync low for exactly pixels 10-11
  - HBlank high for 6 pixels per line
  - VSync low for 14 pixels starting at h=0 of line 5
  - frame pulses every 98 ce_pix
- Set ce_divider=1, then switch to 2 mid-line → period 2 until the next pulse, period 3 afterwards, with no glitch pulse.
- Pass-through, r_in driven with hcount[5:0] → R equals the pixel index on active pixels and 0 during HBlank.
- Colour bars with H_ACTIVE=256 → pixel 0 is R=G=B=63, pixel 32 is R=G=63 with B=0, pixel 224 is all zeros.
- Assert reset asynchronously mid-line → every output reaches its reset value before the next clk_sys edge. Counting restarts at 0,0 after release.
